// File: rtl/io_bus_pkg.sv
// Shared definitions for the two-master I/O bus arbiter: FSM states,
// master index type, bus width, idle address and the hex display base.
package io_bus_pkg;

    localparam int BITS = 32;

    // Parked address while no transfer is in flight; no peripheral decodes it.
    localparam logic [BITS-1:0] IDLE_ADDR = 32'h0000_0000;

    // Hex display register in the peripheral window.
    localparam logic [BITS-1:0] HEX_BASE = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } arbState_t;

    // 0 = M0 (processor data port), 1 = M1 (debug/DMA port).
    typedef logic masterIdx_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Handshake and bus-output bundle between the two masters and the arbiter.
// The tri-state DATABUS stays a plain port of the arbiter so the resolved
// net lives beside its other drivers.
interface io_bus_arbiter_if;
    import io_bus_pkg::*;

    logic            M0_REQ;
    logic            M1_REQ;
    logic [BITS-1:0] M0_ADDR;
    logic [BITS-1:0] M1_ADDR;
    logic [BITS-1:0] M0_WDATA;
    logic [BITS-1:0] M1_WDATA;
    logic            M0_WE;
    logic            M1_WE;
    logic            M0_GNT;
    logic            M1_GNT;
    logic            M0_DONE;
    logic            M1_DONE;
    logic [BITS-1:0] RDATA;
    logic [BITS-1:0] ADDRBUS;
    logic            WE;

    modport master (
        output M0_REQ, M1_REQ, M0_ADDR, M1_ADDR, M0_WDATA, M1_WDATA, M0_WE, M1_WE,
        input  M0_GNT, M1_GNT, M0_DONE, M1_DONE, RDATA, ADDRBUS, WE
    );

    modport slave (
        input  M0_REQ, M1_REQ, M0_ADDR, M1_ADDR, M0_WDATA, M1_WDATA, M0_WE, M1_WE,
        output M0_GNT, M1_GNT, M0_DONE, M1_DONE, RDATA, ADDRBUS, WE
    );

endinterface

// File: rtl/io_arb_pick.sv
// Combinational winner selection for the two-master arbiter.
// Configuration macro: IO_ARB_FIXED_PRIORITY_EN -- when defined, M0 always
// wins a tie; otherwise a tie goes to the master not granted last time.
module io_arb_pick
    import io_bus_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  masterIdx_t lastGnt,
    output masterIdx_t winner,
    output logic       valid
);

`ifdef IO_ARB_FIXED_PRIORITY_EN
    logic unusedLastGnt;
    assign unusedLastGnt = lastGnt;

    // Fixed priority: M0 whenever it asks, M1 only when alone.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (!req0 && req1) begin
            winner = 1'b1;
        end
    end
`else
    // Round-robin: a lone requester wins; a tie goes to the other master.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~lastGnt;
        end else if (req1) begin
            winner = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared FFFF0000 peripheral bus.
// Each transfer runs IDLE -> BUS (one bus cycle) -> ACK (DONE pulse).
// All bus-facing outputs come straight from registers, so no request input
// reaches the bus combinationally.
// Configuration macro: IO_ARB_FIXED_PRIORITY_EN (handled in io_arb_pick).
module io_bus_arbiter
    import io_bus_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    io_bus_arbiter_if.slave bus,
    inout  wire [BITS-1:0]  DATABUS
);

    arbState_t       state;
    masterIdx_t      lastGnt;
    masterIdx_t      curIdx;
    masterIdx_t      pickIdx;
    logic            pickValid;
    logic [BITS-1:0] wdataQ;
    logic [BITS-1:0] rdataQ;
    logic [BITS-1:0] addrBusQ;
    logic            weBusQ;
    logic            driveEn;
    logic [1:0]      gntQ;
    logic [1:0]      doneQ;
    logic [BITS-1:0] selAddr;
    logic [BITS-1:0] selWdata;
    logic            selWe;

    io_arb_pick picker (
        .req0    (bus.M0_REQ),
        .req1    (bus.M1_REQ),
        .lastGnt (lastGnt),
        .winner  (pickIdx),
        .valid   (pickValid)
    );

    assign selAddr  = pickIdx ? bus.M1_ADDR  : bus.M0_ADDR;
    assign selWdata = pickIdx ? bus.M1_WDATA : bus.M0_WDATA;
    assign selWe    = pickIdx ? bus.M1_WE    : bus.M0_WE;

    assign bus.M0_GNT  = gntQ[0];
    assign bus.M1_GNT  = gntQ[1];
    assign bus.M0_DONE = doneQ[0];
    assign bus.M1_DONE = doneQ[1];
    assign bus.RDATA   = rdataQ;
    assign bus.ADDRBUS = addrBusQ;
    assign bus.WE      = weBusQ;
    assign DATABUS     = driveEn ? wdataQ : {BITS{1'bz}};

    // Transfer sequencer: latches the winner in IDLE, owns the bus for one
    // cycle in BUS, then pulses the winner's DONE in ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            lastGnt  <= 1'b1;
            curIdx   <= 1'b0;
            wdataQ   <= '0;
            rdataQ   <= '0;
            addrBusQ <= IDLE_ADDR;
            weBusQ   <= 1'b0;
            driveEn  <= 1'b0;
            gntQ     <= 2'b00;
            doneQ    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    doneQ <= 2'b00;
                    if (pickValid) begin
                        state    <= BUS;
                        curIdx   <= pickIdx;
                        lastGnt  <= pickIdx;
                        gntQ     <= pickIdx ? 2'b10 : 2'b01;
                        addrBusQ <= selAddr;
                        weBusQ   <= selWe;
                        driveEn  <= selWe;
                        wdataQ   <= selWdata;
                    end
                end
                BUS: begin
                    state    <= ACK;
                    gntQ     <= 2'b00;
                    doneQ    <= curIdx ? 2'b10 : 2'b01;
                    addrBusQ <= IDLE_ADDR;
                    weBusQ   <= 1'b0;
                    driveEn  <= 1'b0;
                    if (!weBusQ) begin
                        rdataQ <= DATABUS;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    doneQ <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: expected grants and completions are
// queued when stimulus is driven and matched against the DUT on the falling
// edge. Includes a hex display register model at HEX_BASE.
// Honours IO_ARB_FIXED_PRIORITY_EN for the tie-breaking expectations.
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    typedef struct {
        int          cyc;
        logic        idx;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } gntExp_t;

    typedef struct {
        int          cyc;
        logic        idx;
        logic        we;
        logic [31:0] rdata;
    } doneExp_t;

    logic            CLK = 1'b0;
    logic            RESET;
    wire  [BITS-1:0] DATABUS;
    logic [31:0]     hexReg = 32'd0;
    logic            tbEn = 1'b0;
    logic [31:0]     tbPattern = 32'hA5A5_5A5A;
    logic            devEn;
    logic            monOn = 1'b0;
    int              cyc = 0;
    int              checkCount = 0;
    int              errorCount = 0;
    gntExp_t         gntQ[$];
    doneExp_t        doneQ[$];
    gntExp_t         gMon;
    doneExp_t        dMon;

    io_bus_arbiter_if busIf();

    io_bus_arbiter dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (busIf),
        .DATABUS (DATABUS)
    );

    always #5 CLK = ~CLK;

    // Edge counter used to time-stamp expected grants and completions.
    always @(posedge CLK) cyc <= cyc + 1;

    // Hex display device: answers reads at HEX_BASE, latches writes there.
    assign devEn   = (busIf.ADDRBUS == HEX_BASE) && !busIf.WE;
    assign DATABUS = devEn ? hexReg : (tbEn ? tbPattern : 32'bz);

    always @(posedge CLK) begin
        if (busIf.WE && busIf.ADDRBUS == HEX_BASE) hexReg <= DATABUS;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic setMaster(input logic idx, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (idx) begin
            busIf.M1_REQ = req; busIf.M1_WE = we; busIf.M1_ADDR = addr; busIf.M1_WDATA = wdata;
        end else begin
            busIf.M0_REQ = req; busIf.M0_WE = we; busIf.M0_ADDR = addr; busIf.M0_WDATA = wdata;
        end
    endtask

    task automatic dropReq(input logic idx);
        if (idx) busIf.M1_REQ = 1'b0;
        else     busIf.M0_REQ = 1'b0;
    endtask

    // Single transfer by one master, optionally dropping REQ during BUS.
    task automatic applyStimulus(input logic idx, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input bit dropEarly);
        int k;
        bit seen;
        @(negedge CLK);
        k = cyc + 1;
        setMaster(idx, 1'b1, we, addr, wdata);
        gntQ.push_back('{cyc: k, idx: idx, addr: addr, we: we, wdata: wdata});
        doneQ.push_back('{cyc: k + 1, idx: idx, we: we, rdata: rdata});
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge CLK);
            if (dropEarly && cyc == k) dropReq(idx);
            if (idx ? busIf.M1_DONE : busIf.M0_DONE) seen = 1'b1;
        end
        dropReq(idx);
        checkOutput("doneSeen", {31'd0, seen}, 32'd1);
    endtask

    // Monitor: pops the scoreboard on every grant/DONE, checks idle bus otherwise.
    always @(negedge CLK) begin
        if (monOn) begin
            if (busIf.M0_GNT || busIf.M1_GNT) begin
                if (gntQ.size() == 0) begin
                    checkOutput("unexpGnt", {30'd0, busIf.M1_GNT, busIf.M0_GNT}, 32'd0);
                end else begin
                    gMon = gntQ.pop_front();
                    checkOutput("gntIdx", {30'd0, busIf.M1_GNT, busIf.M0_GNT}, gMon.idx ? 32'd2 : 32'd1);
                    checkOutput("gntCyc", cyc, gMon.cyc);
                    checkOutput("addrBus", busIf.ADDRBUS, gMon.addr);
                    checkOutput("weBus", {31'd0, busIf.WE}, {31'd0, gMon.we});
                    if (gMon.we) checkOutput("dataBus", DATABUS, gMon.wdata);
                end
            end else begin
                checkOutput("idleAddr", busIf.ADDRBUS, IDLE_ADDR);
                checkOutput("idleWe", {31'd0, busIf.WE}, 32'd0);
            end
            if (busIf.M0_DONE || busIf.M1_DONE) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpDone", {30'd0, busIf.M1_DONE, busIf.M0_DONE}, 32'd0);
                end else begin
                    dMon = doneQ.pop_front();
                    checkOutput("doneIdx", {30'd0, busIf.M1_DONE, busIf.M0_DONE}, dMon.idx ? 32'd2 : 32'd1);
                    checkOutput("doneCyc", cyc, dMon.cyc);
                    if (!dMon.we) checkOutput("rdata", busIf.RDATA, dMon.rdata);
                end
            end
        end
    end

    // Bounded run time: a stuck DUT still produces a FAIL line.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int k;
        logic w;
        RESET = 1'b1;
        setMaster(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setMaster(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge CLK);
        checkOutput("rstRdata", busIf.RDATA, 32'd0);
        checkOutput("rstGnt", {30'd0, busIf.M1_GNT, busIf.M0_GNT}, 32'd0);
        checkOutput("rstDone", {30'd0, busIf.M1_DONE, busIf.M0_DONE}, 32'd0);
        checkOutput("rstAddr", busIf.ADDRBUS, IDLE_ADDR);
        checkOutput("rstWe", {31'd0, busIf.WE}, 32'd0);
        RESET = 1'b0;
        monOn = 1'b1;

        @(negedge CLK);
        tbEn = 1'b1;
        #1;
        checkOutput("busFree", DATABUS, 32'hA5A5_5A5A);
        tbEn = 1'b0;

        $display("[TB] M0 write / read of hex display");
        applyStimulus(1'b0, 1'b1, HEX_BASE, 32'h0000_1234, 32'd0, 1'b0);
        checkOutput("hexReg", hexReg, 32'h0000_1234);
        applyStimulus(1'b0, 1'b0, HEX_BASE, 32'd0, 32'h0000_1234, 1'b0);

        $display("[TB] M1 alone");
        applyStimulus(1'b1, 1'b1, 32'hFFFF_0010, 32'h0000_0055, 32'd0, 1'b0);

        $display("[TB] both masters hold REQ for four transfers");
        @(negedge CLK);
        k = cyc + 1;
        setMaster(1'b0, 1'b1, 1'b1, 32'hFFFF_0004, 32'h0000_00A0);
        setMaster(1'b1, 1'b1, 1'b1, 32'hFFFF_0008, 32'h0000_00B1);
        for (int i = 0; i < 4; i++) begin
`ifdef IO_ARB_FIXED_PRIORITY_EN
            w = 1'b0;
`else
            w = i[0];
`endif
            gntQ.push_back('{cyc: k + 3 * i, idx: w, addr: w ? 32'hFFFF_0008 : 32'hFFFF_0004,
                             we: 1'b1, wdata: w ? 32'h0000_00B1 : 32'h0000_00A0});
            doneQ.push_back('{cyc: k + 3 * i + 1, idx: w, we: 1'b1, rdata: 32'd0});
        end
        repeat (11) @(negedge CLK);
        dropReq(1'b0);
        dropReq(1'b1);
        repeat (2) @(negedge CLK);

        $display("[TB] reset during BUS of a write");
        @(negedge CLK);
        k = cyc + 1;
        setMaster(1'b0, 1'b1, 1'b1, HEX_BASE, 32'hDEAD_0000);
        gntQ.push_back('{cyc: k, idx: 1'b0, addr: HEX_BASE, we: 1'b1, wdata: 32'hDEAD_0000});
        @(negedge CLK);
        RESET = 1'b1;
        dropReq(1'b0);
        @(negedge CLK);
        checkOutput("abortDone", {30'd0, busIf.M1_DONE, busIf.M0_DONE}, 32'd0);
        checkOutput("abortGnt", {30'd0, busIf.M1_GNT, busIf.M0_GNT}, 32'd0);
        checkOutput("abortRdata", busIf.RDATA, 32'd0);
        checkOutput("abortAddr", busIf.ADDRBUS, IDLE_ADDR);
        RESET = 1'b0;

        $display("[TB] first tie after reset");
        @(negedge CLK);
        k = cyc + 1;
        setMaster(1'b0, 1'b1, 1'b1, 32'hFFFF_0020, 32'h0000_0C00);
        setMaster(1'b1, 1'b1, 1'b1, 32'hFFFF_0024, 32'h0000_0C01);
        gntQ.push_back('{cyc: k, idx: 1'b0, addr: 32'hFFFF_0020, we: 1'b1, wdata: 32'h0000_0C00});
        doneQ.push_back('{cyc: k + 1, idx: 1'b0, we: 1'b1, rdata: 32'd0});
        gntQ.push_back('{cyc: k + 3, idx: 1'b1, addr: 32'hFFFF_0024, we: 1'b1, wdata: 32'h0000_0C01});
        doneQ.push_back('{cyc: k + 4, idx: 1'b1, we: 1'b1, rdata: 32'd0});
        repeat (2) @(negedge CLK);
        dropReq(1'b0);
        repeat (3) @(negedge CLK);
        dropReq(1'b1);

        $display("[TB] M0 drops REQ during BUS, then M1 reads back");
        applyStimulus(1'b0, 1'b1, HEX_BASE, 32'hCAFE_0001, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, HEX_BASE, 32'd0, 32'hCAFE_0001, 1'b0);

        repeat (5) @(negedge CLK);
        checkOutput("gntQEmpty", gntQ.size(), 32'd0);
        checkOutput("doneQEmpty", doneQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
